// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserializer.
// The PARITY state is only reachable when SERIAL_DESER_PARITY_CHECK_EN is defined.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } deser_state_t;

  localparam int OUT_FIFO_DEPTH = 2;

  // Room for counts 0..WIDTH+1 so the parity build never wraps.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/deser_out_fifo.sv
// Two-entry output buffer of {parity_err, data}.
// A push while full is accepted only when a pop happens in the same cycle.
module deser_out_fifo
  import serial_deser_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic          full
);

  logic [DW-1:0] mem [OUT_FIFO_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic          do_pop;
  logic          do_push;

  assign valid   = (count != 2'd0);
  assign full    = (count == 2'(OUT_FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  // When full, wr_ptr == rd_ptr, so the write lands in the slot being popped.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Reassembles a framed one-bit-per-strobe stream into WIDTH-bit words.
// Define SERIAL_DESER_PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SHIFT_DIRECTION = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity_err,
  output logic             busy,
  output logic             sync_err,
  output logic             overrun
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  deser_state_t   state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           push;
  logic [WIDTH:0] push_word;
  logic           sync_nxt;
  logic           fifo_full;
  logic [WIDTH:0] head;
  logic           pop;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (SHIFT_DIRECTION == 1) return {b, cur[WIDTH-1:1]};
    else                      return {cur[WIDTH-2:0], b};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      sync_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      sync_err <= sync_nxt;
      overrun  <= push && fifo_full && !pop;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    push      = 1'b0;
    push_word = '0;
    sync_nxt  = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        // A marker mid-frame abandons the partial word and restarts on this bit.
        sync_nxt  = (state != ST_IDLE);
        shreg_nxt = shift_in('0, bit_in);
        cnt_nxt   = CW'(1);
        state_nxt = ST_SHIFT;
      end else begin
        case (state)
          ST_SHIFT: begin
            shreg_nxt = shift_in(shreg, bit_in);
            cnt_nxt   = cnt + CW'(1);
            if (cnt == LAST_CNT) begin
`ifdef SERIAL_DESER_PARITY_CHECK_EN
              state_nxt = ST_PARITY;
`else
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
              push      = 1'b1;
              push_word = {1'b0, shreg_nxt};
`endif
            end
          end
          ST_PARITY: begin
            push      = 1'b1;
            push_word = {(^shreg) ^ bit_in, shreg};
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pop  = out_valid && out_ready;
  assign busy = (state != ST_IDLE);

  deser_out_fifo #(.DW(WIDTH + 1)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .valid     (out_valid),
    .full      (fifo_full)
  );

  // Without the parity build the stored flag bit is always written as 0.
  assign out_data       = head[WIDTH-1:0];
  assign out_parity_err = head[WIDTH];

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one bit stream.
// Honours SERIAL_DESER_PARITY_CHECK_EN by appending a parity bit to each frame.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] data_l, data_m;
  logic       valid_l, valid_m, perr_l, perr_m, busy_l, busy_m;
  logic       sync_l, sync_m, ovr_l, ovr_m;

  int checks = 0;
  int failures = 0;
  int sync_cnt_l = 0, sync_cnt_m = 0, ovr_cnt_l = 0, ovr_cnt_m = 0;
  logic [8:0] q_l[$];
  logic [8:0] q_m[$];

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .SHIFT_DIRECTION(1)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready), .out_parity_err(perr_l),
    .busy(busy_l), .sync_err(sync_l), .overrun(ovr_l));

  serial_deserializer #(.WIDTH(8), .SHIFT_DIRECTION(0)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready), .out_parity_err(perr_m),
    .busy(busy_m), .sync_err(sync_m), .overrun(ovr_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    bit_valid = 1'b1; bit_in = b; frame_start = fs;
    tick();
    bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
  endtask

  // seq[0] goes on the wire first; bad flips the parity bit in the parity build.
  task automatic send_frame(input logic [7:0] seq, input int gap, input logic bad,
                            input logic push_exp, input logic chk_busy);
    logic perr_exp;
    logic last_busy;
`ifdef SERIAL_DESER_PARITY_CHECK_EN
    perr_exp  = bad;
    last_busy = 1'b1;
`else
    perr_exp  = 1'b0;
    last_busy = 1'b0;
`endif
    if (push_exp) begin
      q_l.push_back({perr_exp, seq});
      q_m.push_back({perr_exp, rev8(seq)});
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(seq[i], i == 0);
      for (int g = 0; g <= gap; g++) begin
        if (chk_busy) chk("busy_mid", busy_l, (i == 7) ? last_busy : 1'b1);
        if (g < gap) tick();
      end
    end
`ifdef SERIAL_DESER_PARITY_CHECK_EN
    send_bit((^seq) ^ bad, 1'b0);
`endif
    if (chk_busy) chk("busy_end", busy_l, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_l && out_ready) begin
        if (q_l.size() == 0) chk("lsb_unexpected", 1, 0);
        else chk("lsb_word", {perr_l, data_l}, q_l.pop_front());
      end
      if (valid_m && out_ready) begin
        if (q_m.size() == 0) chk("msb_unexpected", 1, 0);
        else chk("msb_word", {perr_m, data_m}, q_m.pop_front());
      end
      sync_cnt_l += int'(sync_l);
      sync_cnt_m += int'(sync_m);
      ovr_cnt_l  += int'(ovr_l);
      ovr_cnt_m  += int'(ovr_m);
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_outs_l", {data_l, valid_l, perr_l, busy_l, sync_l, ovr_l}, 0);
    chk("rst_outs_m", {data_m, valid_m, perr_m, busy_m, sync_m, ovr_m}, 0);
    rst = 1'b0;
    tick();

    // 1: LSB-first 0xA5, latency one edge after the final bit
    chk("t1_idle_valid", valid_l, 1'b0);
    send_frame(8'hA5, 0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_l", valid_l, 1'b1);
    chk("t1_valid_m", valid_m, 1'b1);
    repeat (3) tick();

    // 2: bits 0,0,1,1,1,1,0,0 with 2-cycle gaps -> MSB-first 0x3C
    send_frame(rev8(8'h3C), 2, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();

    // 3: overrun with consumer stalled; back-to-back frames
    out_ready = 1'b0;
    send_frame(8'h11, 0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b0);
    chk("t3_no_ovr_yet", ovr_l, 1'b0);
    send_frame(8'h33, 0, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr_pulse", ovr_l, 1'b1);
    chk("t3_ovr_pulse_m", ovr_m, 1'b1);
    tick();
    chk("t3_ovr_clear", ovr_l, 1'b0);
    chk("t3_head_held", data_l, 8'h11);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t3_drained", valid_l, 1'b0);

    // 4: partial frame then a re-aligning marker
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t4_no_sync_yet", sync_l, 1'b0);
    send_frame(8'hFF, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();

    // 5: reset mid-frame, then a clean frame
    for (int i = 0; i < 4; i++) send_bit(~i[0], i == 0);
    chk("t5_busy_before", busy_l, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs_l", {data_l, valid_l, perr_l, busy_l, sync_l, ovr_l}, 0);
    chk("t5_rst_outs_m", {data_m, valid_m, perr_m, busy_m, sync_m, ovr_m}, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    // 6: good and bad parity, both delivered
    send_frame(8'h07, 0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h07, 0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
`endif

    chk("sync_count_l", sync_cnt_l, 1);
    chk("sync_count_m", sync_cnt_m, 1);
    chk("ovr_count_l", ovr_cnt_l, 1);
    chk("ovr_count_m", ovr_cnt_m, 1);
    chk("q_l_empty", q_l.size(), 0);
    chk("q_m_empty", q_m.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Receive-side companion to the team's parallel-load shift register: accepts the one-bit-per-strobe stream that register shifts out, reassembles it into WIDTH-bit words, and presents them on a valid/ready output through a 2-entry buffer. It sits directly downstream of the serializer, on the link's receive end, and feeds word-level consumers. Frame alignment comes from an explicit `frame_start` marker. Synchronisation loss and buffer overrun are reported as single-cycle pulses.

## Interface
Parameters:
- `WIDTH`, 8, word width in bits (≥2).
- `SHIFT_DIRECTION`, 1, bit order on the wire: 1 = LSB first (matches a right-shifting source), 0 = MSB first.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bit_in` in 1: serial data bit, sampled when `bit_valid`=1.
- `bit_valid` in 1: qualifies `bit_in`; gaps of any length allowed.
- `frame_start` in 1: marks the current `bit_in` as bit 0 of a new frame; ignored unless `bit_valid`=1.
- `out_data` out WIDTH: head word of output buffer.
- `out_valid` out 1: buffer non-empty.
- `out_ready` in 1: consumer accepts head when `out_valid`=1.
- `out_parity_err` out 1: parity flag travelling with head word (0 when feature off).
- `busy` out 1: frame assembly in progress.
- `sync_err` out 1: one-cycle pulse, frame aborted by early `frame_start`.
- `overrun` out 1: one-cycle pulse, completed word dropped because buffer full.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - `bit_valid` with `frame_start` captures the bit, sets bit count to 1, and enters SHIFT.
  - `bit_valid` without `frame_start` is discarded.
- SHIFT, each `bit_valid`:
  - SHIFT_DIRECTION=1: `shreg <= {bit_in, shreg[WIDTH-1:1]}`.
  - SHIFT_DIRECTION=0: `shreg <= {shreg[WIDTH-2:0], bit_in}`.
  - Bit count increments.
- Frame completion: on the WIDTH-th bit, the assembled word is pushed in the same cycle and the FSM returns to IDLE (PARITY when the macro is on).
- `frame_start` with `bit_valid` while in SHIFT or PARITY:
  - Partial frame discarded; `sync_err` pulses.
  - Current bit is taken as bit 0 of a new frame; count=1; FSM stays in or re-enters SHIFT.
- Output buffer: 2-entry FIFO. `out_data`/`out_parity_err` show the head; pop on `out_valid && out_ready`.
- Push while full:
  - With a pop in the same cycle: push accepted.
  - Otherwise: word dropped, `overrun` pulses, buffer unchanged, FSM proceeds normally.
- `busy` = (state != IDLE).

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_parity_err`=0, `busy`=0, `sync_err`=0, `overrun`=0. Buffer emptied, FSM to IDLE, shift register and count cleared.
- Reset mid-frame discards the partial word with no error pulse.
- Latency: `out_valid` rises on the clock edge after the cycle that samples the final frame bit.
- Throughput: one word per WIDTH (or WIDTH+1) valid bits, back-to-back frames with no idle bit.
- `out_data` and `out_parity_err` are held stable while `out_valid && !out_ready`.
- `sync_err` and `overrun` are registered; each is high for exactly one cycle, in the cycle after the cause.

## Configuration
- `SERIAL_DESER_PARITY_CHECK_EN` defined:
  - Frame is WIDTH data bits followed by one even-parity bit, received in state PARITY.
  - Push occurs on the parity bit.
  - The stored `out_parity_err` = XOR of data bits and parity bit.
  - A parity error does not drop the word.
- Undefined:
  - Frame is WIDTH bits and there is no PARITY state.
  - The `out_parity_err` port remains and is tied 0.

## Structure
- Shared package `serial_deser_pkg`:
  - FSM state typedef (IDLE/SHIFT/PARITY).
  - `OUT_FIFO_DEPTH`=2.
  - Bit-count width function `$clog2(WIDTH+2)`.
- One sub-module `deser_out_fifo`: 2-entry synchronous FIFO of {parity_err, data}, with a push-when-full-with-pop rule and a full flag. The top keeps the FSM, shift register, count and error pulses.

## Test plan
1. WIDTH=8, SHIFT_DIRECTION=1, `out_ready`=1; send `frame_start` with bits 1,0,1,0,0,1,0,1 → `out_data`=0xA5, `out_valid` high one cycle after the 8th bit.
2. SHIFT_DIRECTION=0; bits 0,0,1,1,1,1,0,0 with 2-cycle gaps between strobes → `out_data`=0x3C; `busy` high from bit 1 until after bit 8.
3. `out_ready`=0; send frames 0x11, 0x22, 0x33 → `overrun` pulses once after the third frame; raise `out_ready` → 0x11 then 0x22 only.
4. Three bits of a frame, then `frame_start` followed by eight 1s → `sync_err` one pulse; single output word 0xFF.
5. Assert `rst` after 4 bits of a frame → all outputs 0; the next complete frame 0x5A is received correctly.
6. Macro on: 0x07 with parity bit 1 → `out_parity_err`=0; 0x07 with parity bit 0 → `out_parity_err`=1, word still delivered.
